carwash_ctrl: RTL and testbench
===============================

CARWASH_CTRL -- requirements
Module: carwash_ctrl

Interface
REQ-001 SHALL have parameter SPRAY_T, default 16: spray phase length in clk cycles, legal range 1..255.
REQ-002 SHALL have parameter SOAP_T, default 8: soap phase length in clk cycles, legal range 1..255.
REQ-003 SHALL have parameter SOAP_PASSES, default 1: deluxe spray+soap pass count, legal range 1..4.
REQ-004 SHALL have parameter MAX_CREDIT, default 7: credit saturation value; CW = $clog2(MAX_CREDIT+1).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port CLR, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port TOKEN, input, 1 bit: high for one cycle per inserted token.
REQ-008 SHALL have port START, input, 1 bit: start-button request.
REQ-009 SHALL have port DELUXE, input, 1 bit: program select, sampled only in the cycle START is accepted; 0 = basic, 1 = deluxe.
REQ-010 SHALL have port ABORT, input, 1 bit: emergency stop.
REQ-011 SHALL have port SPRAY, output, 1 bit: spray on.
REQ-012 SHALL have port SOAP, output, 1 bit: soap on.
REQ-013 SHALL have port BUSY, output, 1 bit: a wash is in progress.
REQ-014 SHALL have port DONE, output, 1 bit: one-cycle wash-complete pulse.
REQ-015 SHALL have port REJECT, output, 1 bit: one-cycle pulse when START is refused.
REQ-016 SHALL have port OVF, output, 1 bit: one-cycle pulse when a token is lost to saturation.
REQ-017 SHALL have port CREDIT, output, CW bits: current token credit.

Function
REQ-018 SHALL implement states IDLE, PRE (spray), SOAPING, FINAL (spray).
REQ-019 Cost SHALL be 1 token for basic and 2 tokens for deluxe.
REQ-020 In IDLE, START with CREDIT >= cost SHALL be accepted: go to FINAL (basic) or PRE (deluxe) at the next edge.
REQ-021 In IDLE, START with CREDIT < cost SHALL pulse REJECT for one cycle and stay in IDLE.
REQ-022 The cost check SHALL use the pre-edge CREDIT; next CREDIT = min(CREDIT + TOKEN - cost_if_accepted, MAX_CREDIT).
REQ-023 TOKEN SHALL be counted in every state, including during a wash.
REQ-024 A token arriving while CREDIT = MAX_CREDIT, with no simultaneous deduction, SHALL pulse OVF and leave CREDIT unchanged.
REQ-025 Each phase SHALL last exactly its parameter length in cycles; the timer reloads on every phase entry.
REQ-026 Deluxe sequence SHALL be (PRE SPRAY_T -> SOAPING SOAP_T) x SOAP_PASSES, then FINAL SPRAY_T.
REQ-027 Basic sequence SHALL be FINAL SPRAY_T only.
REQ-028 SPRAY SHALL be 1 in PRE and FINAL; SOAP SHALL be 1 in SOAPING; BUSY SHALL be 1 in any state other than IDLE; all three SHALL be Moore outputs.
REQ-029 DONE SHALL be high in the last FINAL cycle only; the state then returns to IDLE.
REQ-030 START SHALL be ignored (no REJECT) while BUSY is high.
REQ-031 ABORT in any wash state SHALL return the state to IDLE at the next edge, with no DONE and no credit refund; ABORT has priority over timer expiry.
REQ-032 ABORT in IDLE SHALL have no effect, and START in the same cycle SHALL still be evaluated.

Reset
REQ-033 CLR low SHALL immediately force the state to IDLE, CREDIT to 0, the timer and pass counter to 0, and SPRAY, SOAP, BUSY, DONE, REJECT and OVF to 0, including mid-wash.
REQ-034 After CLR is released, the first active edge SHALL behave as IDLE.

Structure
REQ-035 State enum, cost constants and the CW width function SHALL live in carwash_pkg.
REQ-036 The down-counting phase timer (load, count, zero flag) SHALL be sub-module phase_timer, instantiated once.

Verification (defaults unless stated)
REQ-037 Bench SHALL cover: 1 token, then START with DELUXE=0 -> SPRAY high for 16 cycles, DONE in the 16th, CREDIT 1 -> 0.
REQ-038 Bench SHALL cover: 2 tokens, then START with DELUXE=1 -> SPRAY 16, SOAP 8, SPRAY 16 (40 cycles BUSY), single DONE.
REQ-039 Bench SHALL cover: 1 token, then START with DELUXE=1 -> REJECT pulse, state IDLE, CREDIT stays 1.
REQ-040 Bench SHALL cover: 9 tokens -> CREDIT = 7 with 2 OVF pulses; then TOKEN and START (DELUXE=1) in the same cycle -> CREDIT = 6.
REQ-041 Bench SHALL cover: ABORT in SOAPING cycle 3 -> IDLE at the next edge, SPRAY = SOAP = 0, no DONE, CREDIT unchanged.
REQ-042 Bench SHALL cover: CLR low mid-FINAL -> all outputs 0 and CREDIT 0 before the next clk edge; SOAP_PASSES=3 deluxe run -> 3 soap bursts of 8 cycles each.

Source files
------------

// File: rtl/carwash_pkg.sv
// rtl/carwash_pkg.sv - shared states, token costs and width helpers for the car wash controller
package carwash_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRE     = 2'd1,
    SOAPING = 2'd2,
    FINAL   = 2'd3
  } wash_state_t;

  localparam int COST_BASIC  = 1;
  localparam int COST_DELUXE = 2;

  // Phase lengths are capped at 255, so an 8-bit timer always suffices.
  localparam int TW = 8;

  function automatic int cw_width(input int max_credit);
    return $clog2(max_credit + 1);
  endfunction

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - loadable down-counter that times one wash phase
module phase_timer
  import carwash_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic [TW-1:0] count,
  output logic          zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/carwash_ctrl.sv
// rtl/carwash_ctrl.sv - token-credit car wash sequencer with basic and deluxe programs
module carwash_ctrl
  import carwash_pkg::*;
#(
  parameter int SPRAY_T     = 16,
  parameter int SOAP_T      = 8,
  parameter int SOAP_PASSES = 1,
  parameter int MAX_CREDIT  = 7
) (
  input  logic                             clk,
  input  logic                             CLR,
  input  logic                             TOKEN,
  input  logic                             START,
  input  logic                             DELUXE,
  input  logic                             ABORT,
  output logic                             SPRAY,
  output logic                             SOAP,
  output logic                             BUSY,
  output logic                             DONE,
  output logic                             REJECT,
  output logic                             OVF,
  output logic [cw_width(MAX_CREDIT)-1:0]  CREDIT
);

  localparam int CW  = cw_width(MAX_CREDIT);
  localparam int CW1 = CW + 1;
  localparam logic [CW1-1:0] MAXV      = CW1'(MAX_CREDIT);
  localparam logic [TW-1:0]  SPRAY_LD  = TW'(SPRAY_T - 1);
  localparam logic [TW-1:0]  SOAP_LD   = TW'(SOAP_T - 1);
  localparam logic [1:0]     LAST_PASS = 2'(SOAP_PASSES - 1);

  wash_state_t    state;
  logic [1:0]     pass_cnt;
  logic           done_r;

  logic           t_load;
  logic [TW-1:0]  t_load_val;
  logic [TW-1:0]  t_count;
  logic           t_zero;

  logic [CW1-1:0] cost;
  logic           accept;
  logic           expire;
  logic [CW1-1:0] credit_sum;

  assign cost   = DELUXE ? CW1'(COST_DELUXE) : CW1'(COST_BASIC);
  assign accept = (state == IDLE) && START && ({1'b0, CREDIT} >= cost);
  assign expire = (state != IDLE) && !ABORT && t_zero;

  // Tokens are credited in every state; the deduction only happens on an accepted start.
  assign credit_sum = {1'b0, CREDIT} + CW1'(TOKEN) - (accept ? cost : '0);

  // Every phase that follows PRE is a soap phase; every other entry is a spray phase.
  assign t_load     = accept || (expire && (state != FINAL));
  assign t_load_val = (state == PRE) ? SOAP_LD : SPRAY_LD;

  phase_timer u_timer (
    .clk      (clk),
    .rst_n    (CLR),
    .load     (t_load),
    .load_val (t_load_val),
    .count    (t_count),
    .zero     (t_zero)
  );

  // An abort in the final cycle cancels the completion pulse.
  assign DONE = done_r && !ABORT;

  always_ff @(posedge clk or negedge CLR) begin
    if (!CLR) begin
      state    <= IDLE;
      pass_cnt <= '0;
      done_r   <= 1'b0;
      SPRAY    <= 1'b0;
      SOAP     <= 1'b0;
      BUSY     <= 1'b0;
      REJECT   <= 1'b0;
      OVF      <= 1'b0;
      CREDIT   <= '0;
    end else begin
      REJECT <= (state == IDLE) && START && !accept;

      if (credit_sum > MAXV) begin
        CREDIT <= MAXV[CW-1:0];
        OVF    <= 1'b1;
      end else begin
        CREDIT <= credit_sum[CW-1:0];
        OVF    <= 1'b0;
      end

      if (state == IDLE) begin
        if (accept) begin
          state    <= DELUXE ? PRE : FINAL;
          pass_cnt <= '0;
          SPRAY    <= 1'b1;
          SOAP     <= 1'b0;
          BUSY     <= 1'b1;
          done_r   <= !DELUXE && (SPRAY_T == 1);
        end
      end else if (ABORT) begin
        state  <= IDLE;
        SPRAY  <= 1'b0;
        SOAP   <= 1'b0;
        BUSY   <= 1'b0;
        done_r <= 1'b0;
      end else if (t_zero) begin
        case (state)
          PRE: begin
            state <= SOAPING;
            SPRAY <= 1'b0;
            SOAP  <= 1'b1;
          end
          SOAPING: begin
            SPRAY <= 1'b1;
            SOAP  <= 1'b0;
            if (pass_cnt == LAST_PASS) begin
              state  <= FINAL;
              done_r <= (SPRAY_T == 1);
            end else begin
              state    <= PRE;
              pass_cnt <= pass_cnt + 1'b1;
            end
          end
          default: begin
            state  <= IDLE;
            SPRAY  <= 1'b0;
            SOAP   <= 1'b0;
            BUSY   <= 1'b0;
            done_r <= 1'b0;
          end
        endcase
      end else if (state == FINAL) begin
        done_r <= (t_count == TW'(1));
      end
    end
  end

endmodule

// File: tb/tb_carwash_ctrl.sv
// tb/tb_carwash_ctrl.sv - self-checking bench for carwash_ctrl
module tb_carwash_ctrl;

  localparam int SPRAY_T    = 16;
  localparam int SOAP_T     = 8;
  localparam int PASSES     = 1;
  localparam int MAX_CREDIT = 7;

  logic clk = 1'b0;
  logic CLR = 1'b0;
  logic TOKEN = 1'b0, START = 1'b0, DELUXE = 1'b0, ABORT = 1'b0;
  logic SPRAY, SOAP, BUSY, DONE, REJECT, OVF;
  logic [2:0] CREDIT;
  logic s2_spray, s2_soap, s2_busy, s2_done, s2_reject, s2_ovf;
  logic [2:0] s2_credit;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  carwash_ctrl #(.SPRAY_T(SPRAY_T), .SOAP_T(SOAP_T), .SOAP_PASSES(PASSES), .MAX_CREDIT(MAX_CREDIT)) dut (
    .clk(clk), .CLR(CLR), .TOKEN(TOKEN), .START(START), .DELUXE(DELUXE), .ABORT(ABORT),
    .SPRAY(SPRAY), .SOAP(SOAP), .BUSY(BUSY), .DONE(DONE), .REJECT(REJECT), .OVF(OVF), .CREDIT(CREDIT)
  );

  carwash_ctrl #(.SPRAY_T(SPRAY_T), .SOAP_T(SOAP_T), .SOAP_PASSES(3), .MAX_CREDIT(MAX_CREDIT)) dut3 (
    .clk(clk), .CLR(CLR), .TOKEN(TOKEN), .START(START), .DELUXE(DELUXE), .ABORT(ABORT),
    .SPRAY(s2_spray), .SOAP(s2_soap), .BUSY(s2_busy), .DONE(s2_done), .REJECT(s2_reject), .OVF(s2_ovf),
    .CREDIT(s2_credit)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Model: credit as an integer, the wash as a queue of per-cycle {spray, soap, done} steps.
  logic [2:0] plan[$];
  int  m_credit = 0;
  bit  m_rej = 0, m_ovf = 0;

  always @(negedge clk) begin
    logic [8:0] act, exp;
    logic [2:0] step;
    bit busy;
    int cost, ded, n;
    bit rej;
    if (!CLR) begin
      plan.delete();
      m_credit = 0; m_rej = 0; m_ovf = 0;
    end
    busy = (plan.size() != 0);
    step = busy ? plan[0] : 3'b000;
    exp  = {step[2], step[1], busy, step[0] && !ABORT, m_rej, m_ovf, 3'(m_credit)};
    act  = {SPRAY, SOAP, BUSY, DONE, REJECT, OVF, CREDIT};
    check("cycle", 32'(act), 32'(exp));
    if (CLR) begin
      ded = 0; rej = 0;
      if (busy) begin
        if (ABORT) plan.delete();
        else plan.delete(0);
      end else if (START) begin
        cost = DELUXE ? 2 : 1;
        if (m_credit >= cost) begin
          ded = cost;
          if (DELUXE) begin
            for (int p = 0; p < PASSES; p++) begin
              repeat (SPRAY_T) plan.push_back(3'b100);
              repeat (SOAP_T) plan.push_back(3'b010);
            end
          end
          repeat (SPRAY_T - 1) plan.push_back(3'b100);
          plan.push_back(3'b101);
        end else begin
          rej = 1;
        end
      end
      n = m_credit + int'(TOKEN) - ded;
      m_ovf = (n > MAX_CREDIT);
      m_credit = (n > MAX_CREDIT) ? MAX_CREDIT : n;
      m_rej = rej;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    CLR = 1'b0; TOKEN = 0; START = 0; DELUXE = 0; ABORT = 0;
    tick(); tick();
    CLR = 1'b1;
    tick();
  endtask

  task automatic give_tokens(input int n);
    for (int i = 0; i < n; i++) begin
      TOKEN = 1'b1;
      tick();
    end
    TOKEN = 1'b0;
  endtask

  task automatic run_count(input int n, input bit use3,
                           output int spray_n, output int soap_n, output int busy_n,
                           output int done_n, output int done_at, output int bursts,
                           output int bmin, output int bmax);
    int run;
    logic sp, so, bu, dn;
    spray_n = 0; soap_n = 0; busy_n = 0; done_n = 0; done_at = -1;
    bursts = 0; bmin = 999; bmax = 0; run = 0;
    for (int i = 0; i < n; i++) begin
      sp = use3 ? s2_spray : SPRAY;
      so = use3 ? s2_soap  : SOAP;
      bu = use3 ? s2_busy  : BUSY;
      dn = use3 ? s2_done  : DONE;
      if (sp) spray_n++;
      if (bu) busy_n++;
      if (dn) begin done_n++; done_at = i; end
      if (so) begin
        soap_n++; run++;
      end else if (run > 0) begin
        bursts++;
        if (run < bmin) bmin = run;
        if (run > bmax) bmax = run;
        run = 0;
      end
      tick();
    end
  endtask

  initial begin
    int sp, so, bu, dn, dat, bs, bmn, bmx, ovf_n;

    do_reset();
    check("reset_credit", 32'(CREDIT), 32'd0);
    check("reset_busy", 32'(BUSY), 32'd0);

    // Basic wash
    give_tokens(1);
    check("basic_credit_before", 32'(CREDIT), 32'd1);
    START = 1'b1; DELUXE = 1'b0;
    tick();
    START = 1'b0;
    check("basic_credit_after", 32'(CREDIT), 32'd0);
    run_count(20, 1'b0, sp, so, bu, dn, dat, bs, bmn, bmx);
    check("basic_spray_cycles", 32'(sp), 32'd16);
    check("basic_done_count", 32'(dn), 32'd1);
    check("basic_done_cycle", 32'(dat), 32'd15);

    // Deluxe wash
    do_reset();
    give_tokens(2);
    START = 1'b1; DELUXE = 1'b1;
    tick();
    START = 1'b0; DELUXE = 1'b0;
    check("deluxe_credit", 32'(CREDIT), 32'd0);
    run_count(50, 1'b0, sp, so, bu, dn, dat, bs, bmn, bmx);
    check("deluxe_spray_cycles", 32'(sp), 32'd32);
    check("deluxe_soap_cycles", 32'(so), 32'd8);
    check("deluxe_busy_cycles", 32'(bu), 32'd40);
    check("deluxe_done_count", 32'(dn), 32'd1);
    check("deluxe_done_cycle", 32'(dat), 32'd39);

    // Refused deluxe with only one token
    do_reset();
    give_tokens(1);
    START = 1'b1; DELUXE = 1'b1;
    tick();
    START = 1'b0; DELUXE = 1'b0;
    check("reject_pulse", 32'(REJECT), 32'd1);
    check("reject_busy", 32'(BUSY), 32'd0);
    check("reject_credit", 32'(CREDIT), 32'd1);
    tick();
    check("reject_one_cycle", 32'(REJECT), 32'd0);

    // Saturation
    do_reset();
    ovf_n = 0;
    for (int i = 0; i < 9; i++) begin
      TOKEN = 1'b1;
      tick();
      if (OVF) ovf_n++;
    end
    TOKEN = 1'b0;
    tick();
    if (OVF) ovf_n++;
    check("sat_credit", 32'(CREDIT), 32'd7);
    check("sat_ovf_pulses", 32'(ovf_n), 32'd2);
    TOKEN = 1'b1; START = 1'b1; DELUXE = 1'b1;
    tick();
    TOKEN = 1'b0; START = 1'b0; DELUXE = 1'b0;
    check("sat_token_and_start", 32'(CREDIT), 32'd6);
    check("sat_no_ovf", 32'(OVF), 32'd0);
    repeat (45) tick();

    // START ignored while busy, then abort in soap cycle 3
    do_reset();
    give_tokens(3);
    START = 1'b1; DELUXE = 1'b1;
    tick();
    DELUXE = 1'b0;
    tick(); tick();
    START = 1'b0;
    check("busy_start_no_reject", 32'(REJECT), 32'd0);
    check("busy_start_credit", 32'(CREDIT), 32'd1);
    repeat (16) tick();
    check("abort_in_soap", 32'(SOAP), 32'd1);
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    check("abort_outputs", 32'({SPRAY, SOAP, BUSY}), 32'd0);
    check("abort_credit", 32'(CREDIT), 32'd1);
    run_count(30, 1'b0, sp, so, bu, dn, dat, bs, bmn, bmx);
    check("abort_no_done", 32'(dn), 32'd0);
    check("abort_stays_idle", 32'(bu), 32'd0);

    // ABORT in IDLE does not block a start
    ABORT = 1'b1; START = 1'b1; DELUXE = 1'b0;
    tick();
    ABORT = 1'b0; START = 1'b0;
    check("idle_abort_start_busy", 32'(BUSY), 32'd1);
    check("idle_abort_start_credit", 32'(CREDIT), 32'd0);
    repeat (20) tick();

    // Asynchronous clear in the middle of FINAL
    do_reset();
    give_tokens(3);
    START = 1'b1;
    tick();
    START = 1'b0;
    repeat (5) tick();
    check("final_before_clr", 32'(SPRAY), 32'd1);
    #2 CLR = 1'b0;
    #1;
    check("clr_outputs", 32'({SPRAY, SOAP, BUSY, DONE, REJECT, OVF}), 32'd0);
    check("clr_credit", 32'(CREDIT), 32'd0);
    tick();
    CLR = 1'b1;
    tick();
    check("after_clr_idle", 32'({BUSY, CREDIT}), 32'd0);

    // Three soap passes on the second instance
    do_reset();
    give_tokens(2);
    START = 1'b1; DELUXE = 1'b1;
    tick();
    START = 1'b0; DELUXE = 1'b0;
    run_count(100, 1'b1, sp, so, bu, dn, dat, bs, bmn, bmx);
    check("pass3_bursts", 32'(bs), 32'd3);
    check("pass3_burst_min", 32'(bmn), 32'd8);
    check("pass3_burst_max", 32'(bmx), 32'd8);
    check("pass3_busy_cycles", 32'(bu), 32'd88);
    check("pass3_spray_cycles", 32'(sp), 32'd64);
    check("pass3_done_count", 32'(dn), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
